mmu_responder: RTL and testbench

Data-memory responder on the far side of the decoder's MMU control lines: it accepts load/store requests driven by `read_mmu`, `write_mmu` and `byte_select_mmu`, plus the ALU-computed address and the store data. It performs word or byte accesses on an internal word-organised data memory with a fixed, parameterised latency, and returns load data with a one-cycle completion pulse. The pipeline stalls on `ready`.

---
 rtl/mmu_responder_pkg.sv | 42 ++++
 rtl/mmu_sram.sv | 48 ++++
 rtl/mmu_responder.sv | 195 +++++++++++++++++++
 tb/tb_mmu_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_responder_pkg.sv
// -----------------------------------------------------------------------------
// mmu_responder_pkg
//   Shared definitions for the data-memory responder:
//     - FSM state codes (IDLE / BUSY / DONE)
//     - word / lane width constants
//     - helpers for byte-lane write enables and load formatting
//   There are no ports. Import with `import mmu_responder_pkg::*;`.
// -----------------------------------------------------------------------------
package mmu_responder_pkg;

    localparam int WORD_W     = 32;
    localparam int LANE_W     = 8;
    localparam int NUM_LANES  = WORD_W / LANE_W;
    localparam int LANE_IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One-hot byte write enable for a single lane.
    function automatic logic [NUM_LANES-1:0] lane_enable(input logic [LANE_IDX_W-1:0] lane);
        return NUM_LANES'(1) << lane;
    endfunction

    // Word loads pass straight through. Byte loads take the selected
    // little-endian lane and sign-extend it.
    function automatic logic [WORD_W-1:0] format_load(
        input logic [WORD_W-1:0]     word,
        input logic [LANE_IDX_W-1:0] lane,
        input logic                  is_byte
    );
        logic [LANE_W-1:0] lane_data;
        lane_data = word[{lane, 3'b000} +: LANE_W];
        if (is_byte) begin
            return {{(WORD_W-LANE_W){lane_data[LANE_W-1]}}, lane_data};
        end
        return word;
    endfunction

endpackage

// File: rtl/mmu_sram.sv
// -----------------------------------------------------------------------------
// mmu_sram
//   Single-port synchronous data memory, DEPTH_WORDS x 32, with a byte write
//   enable. A cycle with en=1 and we=0 is a read. Read data is registered and
//   holds its value until the next read.
//
//   Ports
//     clk    in   clock
//     en     in   access enable
//     we     in   per-lane write enable; all zero means read
//     addr   in   word index
//     wdata  in   write data, lane i is wdata[8*i+7:8*i]
//     rdata  out  registered read data
// -----------------------------------------------------------------------------
module mmu_sram
    import mmu_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [NUM_LANES-1:0] we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // NOTE: the array and its read register have no reset. A reset cannot
    // clear RAM macros, and software does not expect data memory to be
    // cleared. The top level hides rdata until a real load completes.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we == '0) begin
                rdata <= mem[addr];
            end else begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (we[i]) begin
                        mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mmu_responder.sv
// -----------------------------------------------------------------------------
// mmu_responder
//   Load/store responder behind the decoder's MMU control lines. It accepts one
//   request while idle. It waits LATENCY edges and then performs a word or
//   byte access on the internal data memory. It then raises a one-cycle done
//   pulse. Loads return data on rdata, which holds until the next load ends.
//
//   Parameters
//     DEPTH_WORDS  number of 32-bit words; power of two, >= 4
//     LATENCY      edges from acceptance to the access edge; >= 1
//
//   Ports
//     clk              in   clock
//     rst_n            in   asynchronous active-low reset
//     read_mmu         in   load request
//     write_mmu        in   store request; wins over read_mmu
//     byte_select_mmu  in   1 = byte access, 0 = word access
//     addr             in   byte address; wraps modulo the memory size
//     wdata            in   store data; byte stores use wdata[7:0]
//     rdata            out  load result
//     ready            out  idle, so a request is accepted on this edge
//     done             out  one-cycle completion pulse
//     misaligned       out  with done: the word access had addr[1:0] != 0
// -----------------------------------------------------------------------------
module mmu_responder
    import mmu_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_mmu,
    input  logic              write_mmu,
    input  logic              byte_select_mmu,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ready,
    output logic              done,
    output logic              misaligned
);

    localparam int               AW       = $clog2(DEPTH_WORDS);
    localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;

    // Request latched at acceptance.
    logic [AW-1:0]           index_q;
    logic [LANE_IDX_W-1:0]   lane_q;
    logic [WORD_W-1:0]       wdata_q;
    logic                    byte_q;
    logic                    store_q;
    logic                    mis_q;

    // Formatting of the most recent completed load. These registers change
    // only when a load executes, so rdata holds between loads. fmt_zero_q
    // forces rdata to 0 after reset and after a misaligned load. Without it,
    // the un-reset SRAM read register would show through.
    logic                    fmt_zero_q;
    logic                    fmt_byte_q;
    logic [LANE_IDX_W-1:0]   fmt_lane_q;

    logic                    request;
    logic                    accept;
    logic                    execute;

    logic                    sram_en;
    logic [NUM_LANES-1:0]    sram_we;
    logic [WORD_W-1:0]       sram_wdata;
    logic [WORD_W-1:0]       sram_rdata;

    assign request = read_mmu | write_mmu;
    assign accept  = (state_q == ST_IDLE) && request;
    assign execute = (state_q == ST_BUSY) && (cnt_q == '0);

    // ---------------------------------------------------------------- FSM --
    // NOTE: clocked state uses non-blocking assignments only. Every register
    // then samples pre-edge values, whatever the process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output is assigned a default first. No path
    // through the case can then leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (request)        state_d = ST_BUSY;
            ST_BUSY: if (cnt_q == '0)    state_d = ST_DONE;
            ST_DONE:                     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready      = 1'b0;
        done       = 1'b0;
        misaligned = 1'b0;
        unique case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_DONE: begin
                done       = 1'b1;
                misaligned = mis_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------ latency count --
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= CNT_LOAD;
        end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // ---------------------------------------------------- request latches --
    // Only a word access can be misaligned. A byte access may use any lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
            byte_q  <= 1'b0;
            store_q <= 1'b0;
            mis_q   <= 1'b0;
        end else if (accept) begin
            index_q <= addr[AW+1:2];
            lane_q  <= addr[1:0];
            wdata_q <= wdata;
            byte_q  <= byte_select_mmu;
            store_q <= write_mmu;
            mis_q   <= !byte_select_mmu && (addr[1:0] != 2'b00);
        end
    end

    // ------------------------------------------------------- memory access --
    // The access happens on the BUSY-exit edge. A misaligned word access
    // leaves the memory untouched. A byte store copies wdata[7:0] into every
    // lane and enables only the selected lane.
    always_comb begin
        sram_en    = execute && !mis_q;
        sram_we    = '0;
        sram_wdata = wdata_q;
        if (store_q) begin
            if (byte_q) begin
                sram_we    = lane_enable(lane_q);
                sram_wdata = {NUM_LANES{wdata_q[LANE_W-1:0]}};
            end else begin
                sram_we    = '1;
            end
        end
    end

    mmu_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (index_q),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

    // ------------------------------------------------------- load result --
    // The SRAM read register captures the word on the same edge as these
    // format registers. rdata therefore depends only on registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_zero_q <= 1'b1;
            fmt_byte_q <= 1'b0;
            fmt_lane_q <= '0;
        end else if (execute && !store_q) begin
            fmt_zero_q <= mis_q;
            fmt_byte_q <= byte_q;
            fmt_lane_q <= lane_q;
        end
    end

    assign rdata = fmt_zero_q ? '0 : format_load(sram_rdata, fmt_lane_q, fmt_byte_q);

endmodule

// File: tb/tb_mmu_responder.sv
// -----------------------------------------------------------------------------
// tb_mmu_responder
//   Self-checking bench for mmu_responder (DEPTH_WORDS=256, LATENCY=2).
//   A reference memory computes the expected result of each request when the
//   request is driven. The expectation goes into a queue. It is popped and
//   compared when done pulses.
// -----------------------------------------------------------------------------
module tb_mmu_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_mmu;
    logic        write_mmu;
    logic        byte_select_mmu;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        done;
    logic        misaligned;

    always #5 clk = ~clk;

    mmu_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .read_mmu        (read_mmu),
        .write_mmu       (write_mmu),
        .byte_select_mmu (byte_select_mmu),
        .addr            (addr),
        .wdata           (wdata),
        .rdata           (rdata),
        .ready           (ready),
        .done            (done),
        .misaligned      (misaligned)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] last_rdata = 32'h0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    task automatic idle_inputs();
        read_mmu        = 1'b0;
        write_mmu       = 1'b0;
        byte_select_mmu = 1'b0;
        addr            = 32'h0;
        wdata           = 32'h0;
    endtask

    // Reference behaviour of one accepted request. The store wins over the
    // load when both request lines are high.
    task automatic push_expected(input string name, input bit rd, input bit wr,
                                 input bit bsel, input logic [31:0] a,
                                 input logic [31:0] d);
        exp_t        e;
        int          idx;
        int          lane;
        bit          mis;
        logic [7:0]  b;
        logic [31:0] val;
        idx  = int'(a[AW+1:2]);
        lane = int'(a[1:0]);
        mis  = !bsel && (lane != 0);
        if (wr) begin
            if (!mis) begin
                if (bsel) mem_m[idx][lane*8 +: 8] = d[7:0];
                else      mem_m[idx] = d;
            end
            e.rdata = last_rdata;
        end else begin
            if (mis) begin
                val = 32'h0;
            end else if (bsel) begin
                b   = mem_m[idx][lane*8 +: 8];
                val = {{24{b[7]}}, b};
            end else begin
                val = mem_m[idx];
            end
            last_rdata = val;
            e.rdata    = val;
        end
        e.mis  = mis;
        e.name = name;
        sb.push_back(e);
        if (rd && wr) begin
            // The load is dropped, so there is nothing more to model.
        end
    endtask

    // Issue one request and follow it to completion. With disturb set, a
    // different store request is driven throughout BUSY.
    task automatic do_op(input string name, input bit rd, input bit wr,
                         input bit bsel, input logic [31:0] a,
                         input logic [31:0] d, input bit disturb);
        int   k;
        bit   seen;
        bit   ready_bad;
        exp_t e;
        @(negedge clk);
        k = 0;
        while (ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_wait: ready=%b required 1", name, ready);
        end
        read_mmu        = rd;
        write_mmu       = wr;
        byte_select_mmu = bsel;
        addr            = a;
        wdata           = d;
        push_expected(name, rd, wr, bsel, a, d);
        @(posedge clk);
        seen      = 1'b0;
        ready_bad = 1'b0;
        for (k = 1; k <= LAT + 6; k++) begin
            @(negedge clk);
            if (ready !== 1'b0) ready_bad = 1'b1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (disturb) begin
                read_mmu        = 1'b0;
                write_mmu       = 1'b1;
                byte_select_mmu = 1'b0;
                addr            = a ^ 32'h40;
                wdata           = ~d;
            end else begin
                idle_inputs();
            end
        end
        idle_inputs();
        n_checks++;
        if (!seen || k != LAT + 1) begin
            n_fail++;
            $display("FAIL %s latency: done seen=%b at cycle %0d required cycle %0d",
                     name, seen, k, LAT + 1);
        end
        n_checks++;
        if (ready_bad) begin
            n_fail++;
            $display("FAIL %s ready_low: ready was 1 while busy, required 0 for %0d cycles",
                     name, LAT + 1);
        end
        e = sb.pop_front();
        n_checks++;
        if (rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL %s rdata: got %h required %h", name, rdata, e.rdata);
        end
        n_checks++;
        if (misaligned !== e.mis) begin
            n_fail++;
            $display("FAIL %s misaligned: got %b required %b", name, misaligned, e.mis);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || ready !== 1'b1 || misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pulse_end: done=%b ready=%b misaligned=%b required 0 1 0",
                     name, done, ready, misaligned);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || misaligned !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL %s: ready=%b done=%b misaligned=%b rdata=%h required 1 0 0 00000000",
                     name, ready, done, misaligned, rdata);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_release");

        do_op("rst_seed", 1'b0, 1'b1, 1'b0, 32'h40, 32'hA5A5_0001, 1'b0);
        do_op("rst_seed_ld", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0);

        // Start a store and abort it with reset while it is in BUSY.
        @(negedge clk);
        write_mmu = 1'b1;
        addr      = 32'h40;
        wdata     = 32'h5A5A_0002;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: ready=%b required 0", ready);
        end
        rst_n = 1'b0;
        last_rdata = 32'h0;
        #1;
        check_idle_outputs("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_after_abort");
        do_op("reset_store_dropped", 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
    endtask

    task automatic test_word_roundtrip();
        do_op("stw_10", 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
        do_op("ldw_10", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    endtask

    task automatic test_byte();
        do_op("stw_20", 1'b0, 1'b1, 1'b0, 32'h20, 32'h1122_3344, 1'b0);
        do_op("stb_22", 1'b0, 1'b1, 1'b1, 32'h22, 32'hABCD_EF80, 1'b0);
        do_op("ldw_20", 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
        do_op("ldb_22", 1'b1, 1'b0, 1'b1, 32'h22, 32'h0, 1'b0);
        do_op("ldb_23", 1'b1, 1'b0, 1'b1, 32'h23, 32'h0, 1'b0);
        do_op("ldb_20", 1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
    endtask

    task automatic test_misaligned();
        do_op("ldw_21", 1'b1, 1'b0, 1'b0, 32'h21, 32'h0, 1'b0);
        do_op("stw_21", 1'b0, 1'b1, 1'b0, 32'h21, 32'hFFFF_FFFF, 1'b0);
        do_op("ldw_20_after", 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
        do_op("ldw_23", 1'b1, 1'b0, 1'b0, 32'h23, 32'h0, 1'b0);
    endtask

    task automatic test_wrap_priority();
        do_op("stw_400", 1'b0, 1'b1, 1'b0, 32'h400, 32'hCAFE_F00D, 1'b0);
        do_op("ldw_0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        do_op("rd_wr_both", 1'b1, 1'b1, 1'b0, 32'h30, 32'h1357_9BDF, 1'b0);
        do_op("ldw_30", 1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        do_op("stw_50_disturbed", 1'b0, 1'b1, 1'b0, 32'h50, 32'h0BAD_CAFE, 1'b1);
        do_op("ldw_50", 1'b1, 1'b0, 1'b0, 32'h50, 32'h0, 1'b0);
        do_op("ldw_10_untouched", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a_list [6];
        for (int i = 0; i < 6; i++) begin
            a_list[i] = 32'h100 + 32'(i * 4);
            do_op("b2b_st", 1'b0, 1'b1, 1'b0, a_list[i], $urandom, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            do_op("b2b_ldb", 1'b1, 1'b0, 1'b1, a_list[i] + 32'($urandom_range(0, 3)), 32'h0, 1'b0);
            do_op("b2b_ldw", 1'b1, 1'b0, 1'b0, a_list[i], 32'h0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_word_roundtrip();
        test_byte();
        test_misaligned();
        test_wrap_priority();
        test_busy_ignore();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
